serial_deserializer: RTL and testbench

Serial-in, parallel-out receiver for the bit stream produced by the 8-bit parallel-load shift register. It samples one bit per qualified clock, frames words on a start-of-frame marker, and assembles them MSB-first. Each finished word goes into a holding register with a valid/ready handshake and overrun detection. It sits at the receive end of the project_0 serial link, feeding byte-wide consumers.

---
 rtl/serial_deser_pkg.sv | 5 +
 rtl/deser_hold_buf.sv | 46 ++++
 rtl/serial_deserializer.sv | 81 ++++++++
 tb/tb_serial_deserializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// Shared types and defaults for the serial deserializer.
package serial_deser_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} deser_state_e;
  localparam int DW_DEF = 8;
endpackage

// File: rtl/deser_hold_buf.sv
// One-entry holding register: loads on wr_en when empty or draining, 1-cycle latency.
// A write into a full, non-draining buffer is dropped and raises the sticky overrun flag.
module deser_hold_buf #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [DW-1:0] word,
  input  logic          wr_en,
  input  logic          i_par_rdy,
  input  logic          i_clr_ovf,
  output logic [DW-1:0] o_par_out,
  output logic          o_par_vld,
  output logic          o_ovf
);
  logic drain;
  logic accept;
  logic ovf_set;

  assign drain   = o_par_vld & i_par_rdy;
  assign accept  = wr_en & (~o_par_vld | drain);
  assign ovf_set = wr_en & o_par_vld & ~i_par_rdy;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_par_out <= '0;
      o_par_vld <= 1'b0;
    end else if (accept) begin
      o_par_out <= word;
      o_par_vld <= 1'b1;
    end else if (drain) begin
      o_par_vld <= 1'b0;
    end
  end

  // Setting wins over a same-edge clear so no overrun is ever lost.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ovf <= 1'b0;
    end else if (ovf_set) begin
      o_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      o_ovf <= 1'b0;
    end
  end
endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver framed by i_sof; word valid on the edge sampling its last bit.
// Output held in a one-entry buffer; a full, unread buffer drops new words and flags overrun.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_ser_in,
  input  logic          i_ser_vld,
  input  logic          i_sof,
  output logic [DW-1:0] o_par_out,
  output logic          o_par_vld,
  input  logic          i_par_rdy,
  output logic          o_busy,
  output logic          o_ovf,
  input  logic          i_clr_ovf
);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  deser_state_e  state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] shreg, shreg_nxt;
  logic          take_bit;
  logic          word_done;

  assign take_bit  = i_ser_vld & (i_sof | (state == SHIFT));
  assign word_done = i_ser_vld & ~i_sof & (state == SHIFT) & (cnt == LAST);

  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST != 0) shreg_nxt = {shreg[DW-2:0], i_ser_in};
    else                shreg_nxt = {i_ser_in, shreg[DW-1:1]};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_ser_vld && i_sof) state_nxt = SHIFT;
      SHIFT:   if (word_done)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == SHIFT);
  end

  // An SOF mid-frame restarts the count, silently discarding the partial word.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (take_bit) begin
      shreg <= shreg_nxt;
      if (i_sof)          cnt <= CW'(1);
      else if (word_done) cnt <= '0;
      else                cnt <= cnt + CW'(1);
    end
  end

  deser_hold_buf #(.DW(DW)) u_hold (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .word      (shreg_nxt),
    .wr_en     (word_done),
    .i_par_rdy (i_par_rdy),
    .i_clr_ovf (i_clr_ovf),
    .o_par_out (o_par_out),
    .o_par_vld (o_par_vld),
    .o_ovf     (o_ovf)
  );
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer with immediate-assertion checks.
module tb_serial_deserializer;
  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_ser_in;
  logic       i_ser_vld;
  logic       i_sof;
  logic [7:0] o_par_out;
  logic       o_par_vld;
  logic       i_par_rdy;
  logic       o_busy;
  logic       o_ovf;
  logic       i_clr_ovf;

  int checks = 0;
  int errors = 0;

  serial_deserializer #(.DW(8), .MSB_FIRST(1)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_ser_in  (i_ser_in),
    .i_ser_vld (i_ser_vld),
    .i_sof     (i_sof),
    .o_par_out (o_par_out),
    .o_par_vld (o_par_vld),
    .i_par_rdy (i_par_rdy),
    .o_busy    (o_busy),
    .o_ovf     (o_ovf),
    .i_clr_ovf (i_clr_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      i_ser_in  = b[i];
      i_sof     = (i == 7);
      i_ser_vld = 1'b1;
      step();
    end
    i_ser_vld = 1'b0;
    i_sof     = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    i_rstn = 1'b0; i_ser_in = 1'b0; i_ser_vld = 1'b0; i_sof = 1'b0;
    i_par_rdy = 1'b0; i_clr_ovf = 1'b0;
    step(); step();
    check("rst_out",  o_par_out, 8'h00);
    check("rst_vld",  8'(o_par_vld), 8'd0);
    check("rst_busy", 8'(o_busy), 8'd0);
    check("rst_ovf",  8'(o_ovf), 8'd0);
    i_rstn = 1'b1;
    step();

    // Plain frame 0xA5, consumer ready
    i_par_rdy = 1'b1;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      i_ser_in = pat[7-i]; i_sof = (i == 0); i_ser_vld = 1'b1;
      step();
      if (i < 7) begin
        check("a5_busy", 8'(o_busy), 8'd1);
        check("a5_vld_early", 8'(o_par_vld), 8'd0);
      end
    end
    i_ser_vld = 1'b0; i_sof = 1'b0;
    check("a5_out", o_par_out, 8'hA5);
    check("a5_vld", 8'(o_par_vld), 8'd1);
    check("a5_busy_end", 8'(o_busy), 8'd0);
    step();
    check("a5_vld_one_cycle", 8'(o_par_vld), 8'd0);

    // Same frame with a gap cycle after every bit
    for (int i = 0; i < 8; i++) begin
      i_ser_in = pat[7-i]; i_sof = (i == 0); i_ser_vld = 1'b1;
      step();
      if (i < 7) begin
        i_ser_vld = 1'b0; i_sof = 1'b0; i_ser_in = ~i_ser_in;
        step();
        check("gap_busy", 8'(o_busy), 8'd1);
        check("gap_vld_early", 8'(o_par_vld), 8'd0);
      end
    end
    i_ser_vld = 1'b0; i_sof = 1'b0;
    check("gap_out", o_par_out, 8'hA5);
    check("gap_vld", 8'(o_par_vld), 8'd1);
    step();
    check("gap_drain", 8'(o_par_vld), 8'd0);

    // Overrun: 0x3C held, 0xF0 dropped
    i_par_rdy = 1'b0;
    send_byte(8'h3C);
    check("ovr_first_out", o_par_out, 8'h3C);
    check("ovr_first_vld", 8'(o_par_vld), 8'd1);
    check("ovr_first_ovf", 8'(o_ovf), 8'd0);
    send_byte(8'hF0);
    check("ovr_held_out", o_par_out, 8'h3C);
    check("ovr_set", 8'(o_ovf), 8'd1);
    i_par_rdy = 1'b1;
    step();
    check("ovr_drain_vld", 8'(o_par_vld), 8'd0);
    check("ovr_never_f0", o_par_out, 8'h3C);
    check("ovr_sticky", 8'(o_ovf), 8'd1);
    i_clr_ovf = 1'b1;
    step();
    i_clr_ovf = 1'b0;
    check("ovr_clr", 8'(o_ovf), 8'd0);

    // Resync: 4 bits of a frame, then a fresh SOF carrying 0x81
    for (int i = 0; i < 4; i++) begin
      i_ser_in = 1'b1; i_sof = (i == 0); i_ser_vld = 1'b1;
      step();
    end
    i_ser_vld = 1'b0; i_sof = 1'b0;
    check("resync_partial_vld", 8'(o_par_vld), 8'd0);
    check("resync_partial_busy", 8'(o_busy), 8'd1);
    send_byte(8'h81);
    check("resync_out", o_par_out, 8'h81);
    check("resync_vld", 8'(o_par_vld), 8'd1);
    check("resync_ovf", 8'(o_ovf), 8'd0);

    // Bits in IDLE without SOF are discarded; 0x81 stays held
    i_par_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_ser_in = i[0]; i_sof = 1'b0; i_ser_vld = 1'b1;
      step();
    end
    i_ser_vld = 1'b0;
    check("idle_busy", 8'(o_busy), 8'd0);
    check("idle_out", o_par_out, 8'h81);
    check("idle_ovf", 8'(o_ovf), 8'd0);

    // Asynchronous reset at bit 5 of a 0x5A frame
    pat = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      i_ser_in = pat[7-i]; i_sof = (i == 0); i_ser_vld = 1'b1;
      step();
    end
    i_ser_vld = 1'b0; i_sof = 1'b0;
    #2;
    i_rstn = 1'b0;
    #1;
    check("mid_rst_out",  o_par_out, 8'h00);
    check("mid_rst_vld",  8'(o_par_vld), 8'd0);
    check("mid_rst_busy", 8'(o_busy), 8'd0);
    check("mid_rst_ovf",  8'(o_ovf), 8'd0);
    step();
    i_rstn = 1'b1;
    i_par_rdy = 1'b1;
    step();
    send_byte(8'h5A);
    check("post_rst_out", o_par_out, 8'h5A);
    check("post_rst_vld", 8'(o_par_vld), 8'd1);
    step();
    check("post_rst_drain", 8'(o_par_vld), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
